// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive buffer slice.
//   UART_FIFO_DEPTH  : default number of receive FIFO entries
//   timeout_state_e  : encoding of the character-timeout FSM states
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    T_IDLE  = 2'b00,
    T_COUNT = 2'b01,
    T_FIRED = 2'b10
  } timeout_state_e;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_if
// Groups the receiver strobe, the register-side controls and the status
// outputs of uart_rx_fifo.
//   slave  modport : the FIFO itself (takes i_*, drives o_*)
//   master modport : the receiver / register interface driving the FIFO
// Optional members under UART_RX_FIFO_TIMEOUT_EN:
//   i_Timeout_Cycles (idle threshold), o_Timeout_Irq (character timeout)
// ---------------------------------------------------------------------------
interface uart_rx_fifo_if #(
  parameter int DEPTH = uart_pkg::UART_FIFO_DEPTH
);
  localparam int AW = $clog2(DEPTH);

  logic          i_Rx_DV;
  logic [7:0]    i_Rx_Byte;
  logic          i_Rd_En;
  logic          i_Fifo_Clr;
  logic          i_Clr_Ovf;
  logic [AW:0]   i_Watermark;
  logic [7:0]    o_Rd_Data;
  logic          o_Empty;
  logic          o_Full;
  logic [AW:0]   o_Level;
  logic          o_Overflow;
  logic          o_Wm_Irq;
`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic [15:0]   i_Timeout_Cycles;
  logic          o_Timeout_Irq;
`endif

  modport slave (
    input  i_Rx_DV, i_Rx_Byte, i_Rd_En, i_Fifo_Clr, i_Clr_Ovf, i_Watermark,
`ifdef UART_RX_FIFO_TIMEOUT_EN
    input  i_Timeout_Cycles,
    output o_Timeout_Irq,
`endif
    output o_Rd_Data, o_Empty, o_Full, o_Level, o_Overflow, o_Wm_Irq
  );

  modport master (
    output i_Rx_DV, i_Rx_Byte, i_Rd_En, i_Fifo_Clr, i_Clr_Ovf, i_Watermark,
`ifdef UART_RX_FIFO_TIMEOUT_EN
    output i_Timeout_Cycles,
    input  o_Timeout_Irq,
`endif
    input  o_Rd_Data, o_Empty, o_Full, o_Level, o_Overflow, o_Wm_Irq
  );

endinterface

// File: rtl/uart_rx_timeout.sv
// ---------------------------------------------------------------------------
// uart_rx_timeout
// Character-timeout FSM with a 16-bit idle counter. Raises o_irq once the
// FIFO has held data for i_threshold cycles with no accepted push or pop.
// Only instantiated when UART_RX_FIFO_TIMEOUT_EN is defined.
//   i_Clock, rst_ni : clock, synchronous active-low reset
//   i_push, i_pop   : accepted push / pop this cycle
//   i_empty_next    : FIFO will be empty in the next cycle
//   i_flush         : FIFO flush this cycle
//   i_threshold     : idle-cycle threshold, 0 disables
//   o_irq           : registered timeout interrupt (high in T_FIRED)
// ---------------------------------------------------------------------------
module uart_rx_timeout
  import uart_pkg::*;
(
  input  logic        i_Clock,
  input  logic        rst_ni,
  input  logic        i_push,
  input  logic        i_pop,
  input  logic        i_empty_next,
  input  logic        i_flush,
  input  logic [15:0] i_threshold,
  output logic        o_irq
);

  timeout_state_e state_q;
  logic [15:0]    cnt_q;
  logic           irq_q;
  logic [15:0]    cnt_inc;
  logic [15:0]    thr_m1;
  logic           activity;

  assign cnt_inc  = cnt_q + 16'd1;
  assign thr_m1   = i_threshold - 16'd1;
  assign activity = i_push | i_pop;

  // The FSM enters T_FIRED on the same edge the counter would reach
  // threshold-1, so the interrupt appears exactly i_threshold cycles after
  // the last push/pop. A threshold of 1 fires straight from a (re)load.
  // Using >= keeps a threshold lowered mid-count from being skipped over.
  always_ff @(posedge i_Clock) begin
    if (!rst_ni) begin
      state_q <= T_IDLE;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
    end else if (i_flush || i_empty_next || (i_threshold == 16'd0)) begin
      state_q <= T_IDLE;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      case (state_q)
        T_COUNT: begin
          if (activity) begin
            cnt_q   <= '0;
            state_q <= (thr_m1 == 16'd0) ? T_FIRED : T_COUNT;
            irq_q   <= (thr_m1 == 16'd0);
          end else if (cnt_inc >= thr_m1) begin
            cnt_q   <= cnt_inc;
            state_q <= T_FIRED;
            irq_q   <= 1'b1;
          end else begin
            cnt_q   <= cnt_inc;
          end
        end
        T_FIRED: begin
          if (activity) begin
            cnt_q   <= '0;
            state_q <= (thr_m1 == 16'd0) ? T_FIRED : T_COUNT;
            irq_q   <= (thr_m1 == 16'd0);
          end
        end
        default: begin
          // FIFO just became (or is) non-empty: start counting from zero.
          cnt_q   <= '0;
          state_q <= (thr_m1 == 16'd0) ? T_FIRED : T_COUNT;
          irq_q   <= (thr_m1 == 16'd0);
        end
      endcase
    end
  end

  assign o_irq = irq_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Show-ahead receive FIFO between the UART receiver and the register bus.
// Captures bytes on the receiver strobe, reports level/full/empty,
// watermark and sticky overflow status.
//   i_Clock : clock
//   rst_ni  : synchronous active-low reset
//   bus     : uart_rx_fifo_if.slave (strobe, pop, flush, status outputs)
// Optional: define UART_RX_FIFO_TIMEOUT_EN to add the character-timeout
// interrupt (i_Timeout_Cycles / o_Timeout_Irq on the interface).
// ---------------------------------------------------------------------------
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH
) (
  input  logic           i_Clock,
  input  logic           rst_ni,
  uart_rx_fifo_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        overflow_q, overflow_d;
  logic [7:0]  mem_q [DEPTH];

  logic [AW:0] level;
  logic        empty;
  logic        full;
  logic        pop_acc;
  logic        push_acc;
  logic        drop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level    = wr_ptr_q - rd_ptr_q;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_acc  = bus.i_Rd_En & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_acc = bus.i_Rx_DV & (~full | pop_acc);
  assign drop     = bus.i_Rx_DV & full & ~pop_acc;

  // Next-state pointers and overflow. Flush wins over push/pop and the
  // byte lost to a flush is not an overflow; a new drop wins over clear.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (bus.i_Fifo_Clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_acc)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (drop && !bus.i_Fifo_Clr) begin
      overflow_d = 1'b1;
    end else if (bus.i_Clr_Ovf) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately not reset; stale contents are hidden by the
  // empty mask on o_Rd_Data.
  always_ff @(posedge i_Clock) begin
    if (push_acc && !bus.i_Fifo_Clr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= bus.i_Rx_Byte;
    end
  end

  assign bus.o_Rd_Data  = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign bus.o_Empty    = empty;
  assign bus.o_Full     = full;
  assign bus.o_Level    = level;
  assign bus.o_Overflow = overflow_q;
  assign bus.o_Wm_Irq   = (bus.i_Watermark != '0) && (level >= bus.i_Watermark);

`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic empty_next;

  // The timeout FSM reacts to the FIFO's next-cycle occupancy so that a
  // pop emptying the FIFO drops the interrupt on the following cycle.
  assign empty_next = (wr_ptr_d == rd_ptr_d);

  uart_rx_timeout u_timeout (
    .i_Clock      (i_Clock),
    .rst_ni       (rst_ni),
    .i_push       (push_acc),
    .i_pop        (pop_acc),
    .i_empty_next (empty_next),
    .i_flush      (bus.i_Fifo_Clr),
    .i_threshold  (bus.i_Timeout_Cycles),
    .o_irq        (bus.o_Timeout_Irq)
  );
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Self-checking bench for uart_rx_fifo (DEPTH = 16). Expected bytes are
// queued as strobes are issued; a negedge monitor pops and compares them
// whenever a pop is accepted. Status outputs are compared against
// hand-computed constants. Timeout checks run only when
// UART_RX_FIFO_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

  logic clk;
  logic rst_ni;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] sb[$];

  uart_rx_fifo_if #(.DEPTH(16)) bus ();

  uart_rx_fifo #(.DEPTH(16)) dut (
    .i_Clock (clk),
    .rst_ni  (rst_ni),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs; inputs return to idle 1 ns after the edge.
  task automatic apply_stimulus(input logic dv, input logic [7:0] data, input logic rd,
                                input logic clr, input logic clr_ovf, input logic accept);
    bus.i_Rx_DV    = dv;
    bus.i_Rx_Byte  = data;
    bus.i_Rd_En    = rd;
    bus.i_Fifo_Clr = clr;
    bus.i_Clr_Ovf  = clr_ovf;
    if (accept) sb.push_back(data);
    @(posedge clk);
    #1;
    bus.i_Rx_DV    = 1'b0;
    bus.i_Rx_Byte  = 8'h00;
    bus.i_Rd_En    = 1'b0;
    bus.i_Fifo_Clr = 1'b0;
    bus.i_Clr_Ovf  = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] data, input logic accept);
    apply_stimulus(1'b1, data, 1'b0, 1'b0, 1'b0, accept);
  endtask

  task automatic pop_byte();
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every accepted pop must deliver the oldest queued byte.
  always @(negedge clk) begin
    if (rst_ni && bus.i_Rd_En && !bus.o_Empty && !bus.i_Fifo_Clr) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL pop_data: got %0h, expected no data", bus.o_Rd_Data);
      end else begin
        check_output("pop_data", int'(bus.o_Rd_Data), int'(sb.pop_front()));
      end
    end
  end

  initial begin
    rst_ni          = 1'b0;
    bus.i_Rx_DV     = 1'b0;
    bus.i_Rx_Byte   = 8'h00;
    bus.i_Rd_En     = 1'b0;
    bus.i_Fifo_Clr  = 1'b0;
    bus.i_Clr_Ovf   = 1'b0;
    bus.i_Watermark = 5'd0;
`ifdef UART_RX_FIFO_TIMEOUT_EN
    bus.i_Timeout_Cycles = 16'd0;
`endif
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset state");
    check_output("rst_empty", int'(bus.o_Empty), 1);
    check_output("rst_full", int'(bus.o_Full), 0);
    check_output("rst_level", int'(bus.o_Level), 0);
    check_output("rst_rd_data", int'(bus.o_Rd_Data), 8'h00);
    check_output("rst_overflow", int'(bus.o_Overflow), 0);
    check_output("rst_wm_irq", int'(bus.o_Wm_Irq), 0);
`ifdef UART_RX_FIFO_TIMEOUT_EN
    check_output("rst_timeout_irq", int'(bus.o_Timeout_Irq), 0);
`endif
    rst_ni = 1'b1;

    $display("[TB] basic push/pop");
    push_byte(8'hA5, 1'b1);
    check_output("lvl_after_push1", int'(bus.o_Level), 1);
    check_output("head_after_push1", int'(bus.o_Rd_Data), 8'hA5);
    check_output("empty_after_push1", int'(bus.o_Empty), 0);
    push_byte(8'h3C, 1'b1);
    check_output("lvl_after_push2", int'(bus.o_Level), 2);
    check_output("head_after_push2", int'(bus.o_Rd_Data), 8'hA5);
    pop_byte();
    check_output("lvl_after_pop1", int'(bus.o_Level), 1);
    check_output("head_after_pop1", int'(bus.o_Rd_Data), 8'h3C);
    pop_byte();
    check_output("lvl_after_pop2", int'(bus.o_Level), 0);
    check_output("head_when_empty", int'(bus.o_Rd_Data), 8'h00);
    check_output("empty_after_pops", int'(bus.o_Empty), 1);
    pop_byte();
    check_output("lvl_pop_empty", int'(bus.o_Level), 0);

    $display("[TB] push and pop while empty");
    apply_stimulus(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1);
    check_output("lvl_push_pop_empty", int'(bus.o_Level), 1);
    check_output("head_push_pop_empty", int'(bus.o_Rd_Data), 8'h5A);
    pop_byte();

    $display("[TB] fill and overflow");
    for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i), 1'b1);
    check_output("full_after_fill", int'(bus.o_Full), 1);
    check_output("lvl_after_fill", int'(bus.o_Level), 16);
    check_output("ovf_after_fill", int'(bus.o_Overflow), 0);
    push_byte(8'hFF, 1'b0);
    check_output("ovf_after_drop", int'(bus.o_Overflow), 1);
    check_output("lvl_after_drop", int'(bus.o_Level), 16);
    check_output("head_after_drop", int'(bus.o_Rd_Data), 8'h10);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    check_output("ovf_cleared", int'(bus.o_Overflow), 0);
    apply_stimulus(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    check_output("ovf_set_wins", int'(bus.o_Overflow), 1);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    check_output("ovf_cleared2", int'(bus.o_Overflow), 0);

    $display("[TB] full with push and pop");
    apply_stimulus(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b1);
    check_output("lvl_full_push_pop", int'(bus.o_Level), 16);
    check_output("ovf_full_push_pop", int'(bus.o_Overflow), 0);
    check_output("head_full_push_pop", int'(bus.o_Rd_Data), 8'h11);
    for (int i = 0; i < 16; i++) pop_byte();
    check_output("empty_after_drain", int'(bus.o_Empty), 1);

    $display("[TB] watermark");
    bus.i_Watermark = 5'd4;
    push_byte(8'h01, 1'b1);
    push_byte(8'h02, 1'b1);
    push_byte(8'h03, 1'b1);
    check_output("wm_at_3", int'(bus.o_Wm_Irq), 0);
    push_byte(8'h04, 1'b1);
    check_output("wm_at_4", int'(bus.o_Wm_Irq), 1);
    pop_byte();
    check_output("wm_after_pop", int'(bus.o_Wm_Irq), 0);
    push_byte(8'h05, 1'b1);
    push_byte(8'h06, 1'b1);
    check_output("lvl_before_flush", int'(bus.o_Level), 5);

    $display("[TB] flush");
    apply_stimulus(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b0);
    sb.delete();
    check_output("lvl_after_flush", int'(bus.o_Level), 0);
    check_output("empty_after_flush", int'(bus.o_Empty), 1);
    check_output("ovf_after_flush", int'(bus.o_Overflow), 0);
    bus.i_Watermark = 5'd0;
    for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i), 1'b1);
    check_output("wm_disabled", int'(bus.o_Wm_Irq), 0);
    bus.i_Watermark = 5'd16;
    #1;
    check_output("wm_at_depth", int'(bus.o_Wm_Irq), 1);
    bus.i_Watermark = 5'd0;
    push_byte(8'hFF, 1'b0);
    check_output("ovf_before_flush", int'(bus.o_Overflow), 1);
    apply_stimulus(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b0);
    sb.delete();
    check_output("lvl_flush_full", int'(bus.o_Level), 0);
    check_output("ovf_kept_by_flush", int'(bus.o_Overflow), 1);

    $display("[TB] reset mid-operation");
    push_byte(8'h61, 1'b1);
    push_byte(8'h62, 1'b1);
    rst_ni = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    check_output("midrst_level", int'(bus.o_Level), 0);
    check_output("midrst_empty", int'(bus.o_Empty), 1);
    check_output("midrst_rd_data", int'(bus.o_Rd_Data), 8'h00);
    check_output("midrst_overflow", int'(bus.o_Overflow), 0);
    rst_ni = 1'b1;

`ifdef UART_RX_FIFO_TIMEOUT_EN
    begin
      int rise_at;
      int highs;
      $display("[TB] character timeout");
      bus.i_Timeout_Cycles = 16'd40;
      push_byte(8'h42, 1'b1);
      rise_at = 0;
      for (int i = 1; i <= 100; i++) begin
        idle(1);
        if (bus.o_Timeout_Irq) begin
          rise_at = i;
          break;
        end
      end
      // Push in cycle N, IRQ expected in cycle N+40, i.e. after 39 idles.
      check_output("timeout_latency", rise_at, 39);
      pop_byte();
      check_output("timeout_drop_after_pop", int'(bus.o_Timeout_Irq), 0);
      highs = 0;
      for (int i = 0; i < 60; i++) begin
        idle(1);
        if (bus.o_Timeout_Irq) highs++;
      end
      check_output("timeout_quiet_empty", highs, 0);
      bus.i_Timeout_Cycles = 16'd0;
      push_byte(8'h43, 1'b1);
      highs = 0;
      for (int i = 0; i < 60; i++) begin
        idle(1);
        if (bus.o_Timeout_Irq) highs++;
      end
      check_output("timeout_disabled", highs, 0);
      pop_byte();
    end
`endif

    idle(2);
    check_output("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
